// File: rtl/pwconv_pkg.sv
// Shared types and requantisation helpers for the pointwise INT8 conv stage.
package pwconv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    STORE = 2'd2
  } state_e;

  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned WIDE_W    = 64;

  // Round-half-up arithmetic right shift: floor(v / 2^sh + 0.5).
  function automatic logic signed [WIDE_W-1:0] rshift_round(
    input logic signed [WIDE_W-1:0] v,
    input int unsigned              sh
  );
    logic signed [WIDE_W-1:0] half;
    if (sh == 0) return v;
    half = WIDE_W'(1) << (sh - 1);
    return (v + half) >>> sh;
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [WIDE_W-1:0] v);
    if (v > WIDE_W'(127))  return 8'sd127;
    if (v < WIDE_W'(-128)) return 8'h80;
    return v[7:0];
  endfunction

endpackage

// File: rtl/requant_int8.sv
// Combinational requantiser: acc + bias, rounded shift, int8 saturation, optional ReLU.
module requant_int8
  import pwconv_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned SHIFT = 7,
  parameter int unsigned RELU  = 0
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [31:0]      bias_i,
  output logic [7:0]       q_c
);

  logic signed [WIDE_W-1:0] v_c;
  logic signed [WIDE_W-1:0] r_c;
  logic signed [7:0]        s_c;

  always_comb begin
    v_c = WIDE_W'($signed(acc_i)) + WIDE_W'($signed(bias_i));
    r_c = rshift_round(v_c, SHIFT);
    s_c = sat8(r_c);
    q_c = s_c;
    if ((RELU != 0) && s_c[7]) q_c = '0;
  end

endmodule

// File: rtl/pwconv1d_int8.sv
// Pointwise (1x1) INT8 conv: M x C weight mix over C x L activations, one MAC per cycle.
module pwconv1d_int8
  import pwconv_pkg::*;
#(
  parameter int unsigned C     = 4,
  parameter int unsigned M     = 4,
  parameter int unsigned L     = 14,
  parameter int unsigned SHIFT = 7,
  parameter int unsigned RELU  = 0,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [C-1:0][L-1:0][7:0]     x,
  input  logic [M-1:0][C-1:0][7:0]     w,
  input  logic [M-1:0][31:0]           bias,
  output logic                         done,
  output logic                         busy,
  output logic [M-1:0][L-1:0][7:0]     y
);

  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned MW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned LW = (L > 1) ? $clog2(L) : 1;

  if (C > 65535) begin : g_c_check
    $error("pwconv1d_int8: C must not exceed 65535");
  end

  state_e                      state_q, state_d;
  logic [C-1:0][L-1:0][7:0]    x_q, x_d;
  logic [M-1:0][C-1:0][7:0]    w_q, w_d;
  logic [M-1:0][31:0]          bias_q, bias_d;
  logic [MW-1:0]               m_q, m_d;
  logic [LW-1:0]               t_q, t_d;
  logic [CW-1:0]               c_q, c_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [M-1:0][L-1:0][7:0]    y_q, y_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic signed [15:0]          prod_c;
  logic [7:0]                  rq_c;

  requant_int8 #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .RELU  (RELU)
  ) u_requant (
    .acc_i  (acc_q),
    .bias_i (bias_q[m_q]),
    .q_c    (rq_c)
  );

  assign prod_c = 16'($signed(x_q[c_q][t_q])) * 16'($signed(w_q[m_q][c_q]));

  // Next-state, counters, datapath and capture.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    w_d     = w_q;
    bias_d  = bias_q;
    m_d     = m_q;
    t_d     = t_q;
    c_d     = c_q;
    acc_d   = acc_q;
    y_d     = y_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          w_d     = w;
          bias_d  = bias;
          m_d     = '0;
          t_d     = '0;
          c_d     = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod_c);
        if (c_q == CW'(C - 1)) begin
          c_d     = '0;
          state_d = STORE;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      STORE: begin
        y_d[m_q][t_q] = rq_c;
        acc_d         = '0;
        if (t_q == LW'(L - 1)) begin
          t_d = '0;
          m_d = m_q + MW'(1);
        end else begin
          t_d = t_q + LW'(1);
        end
        if ((m_q == MW'(M - 1)) && (t_q == LW'(L - 1))) begin
          m_d     = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      w_q     <= '0;
      bias_q  <= '0;
      m_q     <= '0;
      t_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      bias_q  <= bias_d;
      m_q     <= m_d;
      t_q     <= t_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign done = done_q;
  assign busy = busy_q;
  assign y    = y_q;

endmodule

// File: tb/tb_pwconv1d_int8.sv
// Randomised and directed bench for pwconv1d_int8 with a plain-arithmetic reference model.
module tb_pwconv1d_int8;

  localparam int unsigned C     = 4;
  localparam int unsigned M     = 4;
  localparam int unsigned L     = 14;
  localparam int unsigned SHIFT = 7;
  localparam int          LAT   = M * L * (C + 1);
  localparam int          DL    = 16;
  localparam int          DK    = 3;
  localparam int          DSH   = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [C-1:0][L-1:0][7:0] x;
  logic [M-1:0][C-1:0][7:0] w;
  logic [M-1:0][31:0]       bias;
  logic done0, busy0, done1, busy1;
  logic [M-1:0][L-1:0][7:0] y0, y1;

  int xm   [C][L];
  int wm   [M][C];
  int bm   [M];
  int exp0 [M][L];
  int exp1 [M][L];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwconv1d_int8 #(.C(C), .M(M), .L(L), .SHIFT(SHIFT), .RELU(0), .ACC_W(32)) dut0 (
    .clk(clk), .rst(rst), .start(start), .x(x), .w(w), .bias(bias),
    .done(done0), .busy(busy0), .y(y0)
  );

  pwconv1d_int8 #(.C(C), .M(M), .L(L), .SHIFT(SHIFT), .RELU(1), .ACC_W(32)) dut1 (
    .clk(clk), .rst(rst), .start(start), .x(x), .w(w), .bias(bias),
    .done(done1), .busy(busy1), .y(y1)
  );

  task automatic chk(input string tag, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Rounding by integer division with explicit floor correction, then clamp.
  function automatic int round_sat(input longint v, input int sh, input bit relu);
    longint num, den, q;
    if (sh == 0) q = v;
    else begin
      den = longint'(2) ** sh;
      num = v + den / 2;
      q   = num / den;
      if ((num % den != 0) && (num < 0)) q = q - 1;
    end
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    if (relu && q < 0) q = 0;
    return int'(q);
  endfunction

  task automatic build_expect();
    longint acc;
    for (int m = 0; m < M; m++)
      for (int t = 0; t < L; t++) begin
        acc = longint'(bm[m]);
        for (int c = 0; c < C; c++) acc += longint'(xm[c][t] * wm[m][c]);
        exp0[m][t] = round_sat(acc, SHIFT, 1'b0);
        exp1[m][t] = round_sat(acc, SHIFT, 1'b1);
      end
  endtask

  task automatic apply_inputs();
    for (int c = 0; c < C; c++)
      for (int t = 0; t < L; t++) x[c][t] = 8'(xm[c][t]);
    for (int m = 0; m < M; m++) begin
      for (int c = 0; c < C; c++) w[m][c] = 8'(wm[m][c]);
      bias[m] = 32'(bm[m]);
    end
    build_expect();
  endtask

  task automatic set_all(input int xv, input int wv, input int bv);
    for (int c = 0; c < C; c++)
      for (int t = 0; t < L; t++) xm[c][t] = xv;
    for (int m = 0; m < M; m++) begin
      for (int c = 0; c < C; c++) wm[m][c] = wv;
      bm[m] = bv;
    end
  endtask

  task automatic check_y(input string tag);
    for (int m = 0; m < M; m++)
      for (int t = 0; t < L; t++) begin
        chk($sformatf("%s_y0[%0d][%0d]", tag, m, t), longint'($signed(y0[m][t])), exp0[m][t]);
        chk($sformatf("%s_y1[%0d][%0d]", tag, m, t), longint'($signed(y1[m][t])), exp1[m][t]);
      end
  endtask

  // Pulse start, count edges to done, optionally fire a stray start mid-batch.
  task automatic run_batch(input string tag, input int extra_at);
    int lat;
    bit busy_ok;
    bit done1_ok;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat      = -1;
    busy_ok  = 1'b1;
    done1_ok = 1'b0;
    for (int n = 1; n <= LAT + 100; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done0) begin
        lat      = n;
        done1_ok = done1;
        break;
      end
      if (!busy0 || !busy1) busy_ok = 1'b0;
      if (n == extra_at) begin
        start = 1'b1;
        for (int c = 0; c < C; c++)
          for (int t = 0; t < L; t++) x[c][t] = 8'($urandom);
      end
    end
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_done1_sync"}, longint'(done1_ok), 1);
    chk({tag, "_busy_during"}, longint'(busy_ok), 1);
    chk({tag, "_busy_at_done"}, longint'(busy0), 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, longint'(done0), 0);
    check_y(tag);
  endtask

  initial begin
    int xr [C][DL];
    int s;
    bit seen;

    rst   = 1'b1;
    start = 1'b0;
    set_all(0, 0, 0);
    apply_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done", longint'(done0), 0);
    chk("rst_busy", longint'(busy0), 0);
    for (int m = 0; m < M; m++)
      for (int t = 0; t < L; t++) chk("rst_y", longint'($signed(y0[m][t])), 0);

    // Identity weights
    set_all(100, 0, 0);
    for (int m = 0; m < M; m++) wm[m][m] = 64;
    apply_inputs();
    run_batch("id100", -1);
    chk("id100_const", longint'($signed(y0[2][5])), 50);

    set_all(-3, 0, 0);
    for (int m = 0; m < M; m++) wm[m][m] = 64;
    apply_inputs();
    run_batch("idm3", -1);
    chk("idm3_const", longint'($signed(y0[1][7])), -1);
    chk("idm3_relu_const", longint'($signed(y1[1][7])), 0);

    // Saturation
    set_all(127, 127, 0);
    apply_inputs();
    run_batch("satp", -1);
    chk("satp_const", longint'($signed(y0[3][13])), 127);

    set_all(-128, 127, 0);
    apply_inputs();
    run_batch("satn", -1);
    chk("satn_const", longint'($signed(y0[0][0])), -128);
    chk("satn_relu_const", longint'($signed(y1[0][0])), 0);

    // Bias offsets
    set_all(0, 0, 0);
    for (int m = 0; m < M; m++) bm[m] = (m - 1) * 128;
    apply_inputs();
    run_batch("bias", -1);
    chk("bias_m0", longint'($signed(y0[0][3])), -1);
    chk("bias_m3", longint'($signed(y0[3][3])), 2);

    // Rounding ties
    set_all(0, 0, 0);
    xm[0][0] = 1;
    for (int m = 0; m < M; m++) wm[m][0] = 64;
    apply_inputs();
    run_batch("tiep", -1);
    chk("tiep_const", longint'($signed(y0[2][0])), 1);

    xm[0][0] = -1;
    apply_inputs();
    run_batch("tien", -1);
    chk("tien_const", longint'($signed(y0[2][0])), 0);

    // Random batches, the second with a stray start and changed inputs mid-batch
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < C; c++)
        for (int t = 0; t < L; t++) xm[c][t] = int'($urandom_range(255)) - 128;
      for (int m = 0; m < M; m++) begin
        for (int c = 0; c < C; c++) wm[m][c] = int'($urandom_range(255)) - 128;
        bm[m] = int'($urandom_range(16383)) - 8192;
      end
      apply_inputs();
      run_batch($sformatf("rnd%0d", r), (r == 1) ? 100 : -1);
    end

    // Reset mid-operation aborts the batch
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", longint'(busy0), 0);
    chk("abort_done", longint'(done0), 0);
    for (int m = 0; m < M; m++)
      for (int t = 0; t < L; t++) chk("abort_y", longint'($signed(y0[m][t])), 0);
    seen = 1'b0;
    for (int n = 0; n < LAT + 20; n++) begin
      @(posedge clk);
      #1;
      if (done0 || done1) seen = 1'b1;
    end
    chk("abort_no_done", longint'(seen), 0);
    run_batch("after_abort", -1);

    // Depthwise-separable chain: depthwise stage modelled here, feeding this block
    for (int c = 0; c < C; c++)
      for (int i = 0; i < DL; i++) xr[c][i] = ((c * 7 + i * 3) % 31) - 15;
    for (int c = 0; c < C; c++)
      for (int t = 0; t < L; t++) begin
        s = 0;
        for (int j = 0; j < DK; j++) s += xr[c][t + j] * (j + 1) * ((c % 2 != 0) ? -1 : 1) * 8;
        xm[c][t] = round_sat(longint'(s), DSH, 1'b0);
      end
    for (int m = 0; m < M; m++) begin
      for (int c = 0; c < C; c++) wm[m][c] = (m + 1) * ((c % 2 != 0) ? -1 : 1) * 16;
      bm[m] = m * 128;
    end
    apply_inputs();
    run_batch("chain", -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
